// File: rtl/dlsc_sp605_ch7301c_init.sv
// Power-up I2C register loader for the SP605 CH7301C DVI transmitter; releases px_en once every write is ACKed.
// Optional build macro DLSC_CH7301C_INIT_RETRY_EN: retry a NACKed table entry up to 3 times before giving up.
module dlsc_sp605_ch7301c_init #(
  parameter int         I2C_DIV    = 250,
  parameter logic [6:0] I2C_ADDR   = 7'h76,
  parameter int         RESET_WAIT = 100000,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic error,
  output logic px_en,
  input  logic scl_i,
  output logic scl_oe,
  input  logic sda_i,
  output logic sda_oe
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WAIT, ST_START, ST_BYTE, ST_ACK, ST_STOP, ST_GAP, ST_DONE, ST_ERR
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(I2C_DIV - 1);
  localparam logic [31:0] WAIT_LAST = 32'(RESET_WAIT - 1);
  localparam logic [3:0]  TBL_END   = 4'd9;

  state_t      state_q, state_d;
  logic [15:0] qCnt_q;
  logic [1:0]  quarter_q;
  logic [31:0] waitCnt_q;
  logic [2:0]  bitCnt_q;
  logic [1:0]  byteCnt_q;
  logic [3:0]  tblIdx_q;
  logic        ackSample_q;
  logic        giveUp_q;
  logic        autoPend_q;
  logic        busy_q, done_q, error_q, pxEn_q;
  logic        sclOe_q, sdaOe_q;
`ifdef DLSC_CH7301C_INIT_RETRY_EN
  logic [1:0]  retry_q;
`endif

  logic        inPhase, hold, qLast, phaseEnd;
  logic        sclOeD, sdaOeD;
  logic [15:0] entry;
  logic [7:0]  curByte;
  logic        curBit;
  logic        enterWait, enterDone, enterErr;

  function automatic logic [15:0] tableEntry(input logic [3:0] idx);
    logic [15:0] e;
    case (idx)
      4'd0:    e = 16'h1C04;
      4'd1:    e = 16'h1D45;
      4'd2:    e = 16'h1F80;
      4'd3:    e = 16'h2109;
      4'd4:    e = 16'h3308;
      4'd5:    e = 16'h3416;
      4'd6:    e = 16'h3660;
      4'd7:    e = 16'h4818;
      4'd8:    e = 16'h49C0;
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  assign entry   = tableEntry(tblIdx_q);
  assign curByte = (byteCnt_q == 2'd0) ? {I2C_ADDR, 1'b0} :
                   (byteCnt_q == 2'd1) ? entry[15:8] : entry[7:0];
  assign curBit  = curByte[3'd7 - bitCnt_q];

  assign inPhase = (state_q == ST_START) || (state_q == ST_BYTE) || (state_q == ST_ACK) ||
                   (state_q == ST_STOP)  || (state_q == ST_GAP);

  // A slave stretches only once our registered release has reached the pad.
  assign hold     = inPhase && !sclOeD && !sclOe_q && !scl_i;
  assign qLast    = (qCnt_q == DIV_LAST) && !hold;
  assign phaseEnd = qLast && (quarter_q == 2'd3);

  always_comb begin
    sclOeD = 1'b0;
    sdaOeD = 1'b0;
    case (state_q)
      ST_START: begin
        sdaOeD = quarter_q[1];
        sclOeD = (quarter_q == 2'd3);
      end
      ST_BYTE: begin
        sclOeD = (quarter_q == 2'd0) || (quarter_q == 2'd3);
        sdaOeD = ~curBit;
      end
      ST_ACK: begin
        sclOeD = (quarter_q == 2'd0) || (quarter_q == 2'd3);
      end
      ST_STOP: begin
        sdaOeD = ~quarter_q[1];
        sclOeD = (quarter_q == 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start || autoPend_q) state_d = ST_WAIT;
      ST_WAIT:  if (waitCnt_q == WAIT_LAST) state_d = ST_START;
      ST_START: if (phaseEnd) state_d = ST_BYTE;
      ST_BYTE:  if (phaseEnd && bitCnt_q == 3'd7) state_d = ST_ACK;
      ST_ACK: begin
        if (phaseEnd) begin
          if (ackSample_q || byteCnt_q == 2'd2) state_d = ST_STOP;
          else                                  state_d = ST_BYTE;
        end
      end
      ST_STOP:  if (phaseEnd) state_d = giveUp_q ? ST_ERR : ST_GAP;
      ST_GAP:   if (phaseEnd) state_d = (tblIdx_q == TBL_END) ? ST_DONE : ST_START;
      ST_DONE,
      ST_ERR:   if (start) state_d = ST_WAIT;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign enterWait = (state_q != ST_WAIT) && (state_d == ST_WAIT);
  assign enterDone = (state_q != ST_DONE) && (state_d == ST_DONE);
  assign enterErr  = (state_q != ST_ERR)  && (state_d == ST_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qCnt_q      <= '0;
      quarter_q   <= '0;
      waitCnt_q   <= '0;
      bitCnt_q    <= '0;
      byteCnt_q   <= '0;
      tblIdx_q    <= '0;
      ackSample_q <= 1'b0;
      giveUp_q    <= 1'b0;
      autoPend_q  <= AUTO_START;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      pxEn_q      <= 1'b0;
      sclOe_q     <= 1'b0;
      sdaOe_q     <= 1'b0;
`ifdef DLSC_CH7301C_INIT_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      sclOe_q   <= sclOeD;
      sdaOe_q   <= sdaOeD;
      pxEn_q    <= enterWait ? 1'b0 : done_q;
      waitCnt_q <= (state_q == ST_WAIT) ? waitCnt_q + 32'd1 : '0;

      if (state_q == ST_IDLE && state_d == ST_WAIT) autoPend_q <= 1'b0;

      if (!inPhase) begin
        qCnt_q    <= '0;
        quarter_q <= '0;
      end else if (!hold) begin
        if (qCnt_q == DIV_LAST) begin
          qCnt_q    <= '0;
          quarter_q <= quarter_q + 2'd1;
        end else begin
          qCnt_q <= qCnt_q + 16'd1;
        end
      end

      if (state_q == ST_ACK && quarter_q == 2'd2 && qLast) ackSample_q <= sda_i;

      if (state_q == ST_START) begin
        bitCnt_q  <= '0;
        byteCnt_q <= '0;
      end
      if (state_q == ST_BYTE && phaseEnd) bitCnt_q <= bitCnt_q + 3'd1;

      // The entry index only advances on an ACKed data byte, so a retry reissues the same write.
      if (state_q == ST_ACK && phaseEnd) begin
        if (ackSample_q) begin
`ifdef DLSC_CH7301C_INIT_RETRY_EN
          if (retry_q == 2'd3) giveUp_q <= 1'b1;
          else                 retry_q  <= retry_q + 2'd1;
`else
          giveUp_q <= 1'b1;
`endif
        end else if (byteCnt_q == 2'd2) begin
          tblIdx_q <= tblIdx_q + 4'd1;
`ifdef DLSC_CH7301C_INIT_RETRY_EN
          retry_q  <= '0;
`endif
        end else begin
          byteCnt_q <= byteCnt_q + 2'd1;
        end
      end

      if (enterWait) begin
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
        error_q  <= 1'b0;
        tblIdx_q <= '0;
        giveUp_q <= 1'b0;
`ifdef DLSC_CH7301C_INIT_RETRY_EN
        retry_q  <= '0;
`endif
      end
      if (enterDone) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
      if (enterErr) begin
        error_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign px_en  = pxEn_q;
  assign scl_oe = sclOe_q;
  assign sda_oe = sdaOe_q;

endmodule

// File: tb/tb_dlsc_sp605_ch7301c_init.sv
// Bench for dlsc_sp605_ch7301c_init: I2C slave model with a write scoreboard and a table of scenarios.
module tb_dlsc_sp605_ch7301c_init;

  localparam int DIV = 4;
  localparam int RW  = 16;
`ifdef DLSC_CH7301C_INIT_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  localparam int MAX_ATT = RETRY ? 4 : 1;
  localparam logic [15:0] TBL [9] = '{16'h1C04, 16'h1D45, 16'h1F80, 16'h2109, 16'h3308,
                                      16'h3416, 16'h3660, 16'h4818, 16'h49C0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, error, pxEn, sclOe, sdaOe;
  logic sHold = 1'b0;
  logic sAck = 1'b0;
  logic scl, sda;

  assign scl = ~(sclOe | sHold);
  assign sda = ~(sdaOe | sAck);

  dlsc_sp605_ch7301c_init #(.I2C_DIV(DIV), .I2C_ADDR(7'h76), .RESET_WAIT(RW), .AUTO_START(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .px_en(pxEn), .scl_i(scl), .scl_oe(sclOe), .sda_i(sda), .sda_oe(sdaOe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard of expected (reg,data) writes, filled when a scenario is launched.
  logic [15:0] expQ[$];

  logic       prevScl = 1'b1, prevSda = 1'b1, curScl, curSda, inAck = 1'b0;
  logic [7:0] sr = '0, sReg = '0, nackReg = 8'hFF;
  int         sBit = 0, sByte = 0, nackLeft = 0, writesSeen = 0;
  int         firstFallCyc = -1, lastFall = 0, holdCnt = 0, stretchExtra = -1;
  bit         stretchPend = 0, measureNext = 0;

  // Slave model: samples the bus on falling clk edges, then updates its own drives.
  always @(negedge clk) begin
    curScl = scl;
    curSda = sda;
    if (!rst_n) begin
      sHold = 1'b0; sAck = 1'b0; inAck = 1'b0; sBit = 0; sByte = 0;
    end else begin
      if (prevScl && curScl && prevSda && !curSda) begin
        sBit = 0; sByte = 0; inAck = 1'b0;
        if (firstFallCyc < 0) firstFallCyc = cyc;
      end else if (!prevScl && curScl) begin
        if (!inAck) begin sr = {sr[6:0], curSda}; sBit++; end
      end else if (prevScl && !curScl) begin
        if (measureNext && sByte == 0 && sBit == 3) begin
          stretchExtra = (cyc - lastFall) - 4 * DIV;
          measureNext = 0;
        end
        lastFall = cyc;
        if (inAck) begin
          sAck = 1'b0; inAck = 1'b0; sBit = 0; sByte++;
        end else if (sBit == 8) begin
          inAck = 1'b1;
          if (sByte == 0) begin
            checkOutput("addr byte", int'(sr), 'hEC);
            sAck = (sr == 8'hEC);
          end else if (sByte == 1) begin
            sReg = sr; sAck = 1'b1;
          end else begin
            writesSeen++;
            if (expQ.size() == 0) begin
              checkOutput("unexpected write", int'({sReg, sr}), -1);
            end else begin
              logic [15:0] e;
              e = expQ.pop_front();
              checkOutput("write reg", int'(sReg), int'(e[15:8]));
              checkOutput("write data", int'(sr), int'(e[7:0]));
            end
            if (sReg == nackReg && nackLeft > 0) begin nackLeft--; sAck = 1'b0; end
            else sAck = 1'b1;
          end
        end else if (stretchPend && sByte == 0 && sBit == 2) begin
          sHold = 1'b1; holdCnt = 0; stretchPend = 0; measureNext = 1;
        end
      end
      if (sHold && !sclOe) begin
        holdCnt++;
        if (holdCnt >= 37) sHold = 1'b0;
      end
    end
    prevScl = curScl;
    prevSda = curSda;
  end

  typedef struct {
    string      name;
    logic [7:0] nackReg;
    int         nackTimes;
    bit         stretch;
    bit         pulseMid;
    bit         autoRun;
    bit         expDone;
    bit         expErr;
  } vec_t;

  vec_t vecs[4];

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int expN, n, relCyc, doneCyc;
    bit timedOut;
    for (int i = 0; i < 9; i++) begin
      int att;
      att = 1;
      if (TBL[i][15:8] == v.nackReg) att = (v.nackTimes + 1 > MAX_ATT) ? MAX_ATT : v.nackTimes + 1;
      for (int k = 0; k < att; k++) expQ.push_back(TBL[i]);
      if (TBL[i][15:8] == v.nackReg && v.nackTimes >= MAX_ATT) break;
    end
    expN = expQ.size();
    writesSeen = 0;
    nackReg = v.nackReg;
    nackLeft = v.nackTimes;
    stretchPend = v.stretch;
    stretchExtra = -1;
    relCyc = cyc;
    if (v.autoRun) begin
      firstFallCyc = -1;
      rst_n = 1'b1;
      relCyc = cyc;
      repeat (3) @(negedge clk);
      checkOutput({v.name, " busy in wait"}, int'(busy), 1);
    end else begin
      pulseStart();
      checkOutput({v.name, " px_en drop"}, int'(pxEn), 0);
      checkOutput({v.name, " busy on start"}, int'(busy), 1);
      checkOutput({v.name, " done cleared"}, int'(done), 0);
    end
    if (v.pulseMid) begin
      repeat (600) @(negedge clk);
      pulseStart();
      @(negedge clk);
      checkOutput({v.name, " busy after mid start"}, int'(busy), 1);
    end
    n = 0;
    while (!(done || error) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    timedOut = (n >= 30000);
    doneCyc = cyc;
    checkOutput({v.name, " finished in bound"}, int'(timedOut), 0);
    checkOutput({v.name, " done"}, int'(done), int'(v.expDone));
    checkOutput({v.name, " error"}, int'(error), int'(v.expErr));
    checkOutput({v.name, " busy idle"}, int'(busy), 0);
    checkOutput({v.name, " px_en lag"}, int'(pxEn), 0);
    @(negedge clk);
    checkOutput({v.name, " px_en"}, int'(pxEn), int'(v.expDone));
    checkOutput({v.name, " writes seen"}, writesSeen, expN);
    checkOutput({v.name, " writes left"}, expQ.size(), 0);
    if (v.autoRun) begin
      checkRange({v.name, " first SDA fall"}, firstFallCyc - relCyc, RW + 2 * DIV, RW + 2 * DIV + 3);
      checkRange({v.name, " done time"}, doneCyc - relCyc, RW + 9 * 120 * DIV, RW + 9 * 120 * DIV + 2);
    end
    if (v.stretch) checkRange({v.name, " stretch extra"}, stretchExtra, 36, 38);
    expQ.delete();
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int n;
    vecs[0] = '{"auto",    8'hFF, 0, 1'b0, 1'b0, 1'b1, 1'b1,   1'b0};
    vecs[1] = '{"stretch", 8'hFF, 0, 1'b1, 1'b1, 1'b0, 1'b1,   1'b0};
    vecs[2] = '{"nack21",  8'h21, 4, 1'b0, 1'b0, 1'b0, 1'b0,   1'b1};
    vecs[3] = '{"nack33",  8'h33, 2, 1'b0, 1'b0, 1'b0, RETRY, !RETRY};

    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset error", int'(error), 0);
    checkOutput("reset px_en", int'(pxEn), 0);
    checkOutput("reset scl_oe", int'(sclOe), 0);
    checkOutput("reset sda_oe", int'(sdaOe), 0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    // Asynchronous reset in the middle of a data byte must free the bus with no clock edge.
    for (int i = 0; i < 9; i++) expQ.push_back(TBL[i]);
    nackReg = 8'hFF;
    nackLeft = 0;
    pulseStart();
    n = 0;
    while (!(sByte == 2 && sBit == 3) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach data byte", int'(n >= 3000), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid reset scl_oe", int'(sclOe), 0);
    checkOutput("mid reset sda_oe", int'(sdaOe), 0);
    checkOutput("mid reset busy", int'(busy), 0);
    checkOutput("mid reset done", int'(done), 0);
    checkOutput("mid reset error", int'(error), 0);
    checkOutput("mid reset px_en", int'(pxEn), 0);
    expQ.delete();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
